// File: rtl/cache_defs.sv
// Shared data-cache definitions: set count and the tag controller state encoding.
package cache_defs;

    localparam int unsigned DCACHE_NO_OF_SETS = 128;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } dcache_tag_ctrl_state_t;

endpackage

// File: rtl/dcache_tag_ctrl.sv
// Data-cache tag RAM controller: post-reset and on-demand invalidation sweeps,
// plus update/lookup arbitration onto the single tag RAM port.
module dcache_tag_ctrl
    import cache_defs::*;
#(
    parameter int unsigned ADDR_WIDTH = $clog2(DCACHE_NO_OF_SETS),
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  init_done,

    input  logic                  lkup_req,
    input  logic [ADDR_WIDTH-1:0] lkup_addr,
    output logic                  lkup_gnt,
    output logic                  lkup_rvalid,
    output logic [DATA_WIDTH-1:0] lkup_rdata,

    input  logic                  upd_req,
    input  logic [ADDR_WIDTH-1:0] upd_addr,
    input  logic [NUM_COL-1:0]    upd_wr_en,
    input  logic [DATA_WIDTH-1:0] upd_wdata,
    output logic                  upd_gnt,

    output logic                  ram_req,
    output logic [NUM_COL-1:0]    ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,

    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_SET = '1;

    dcache_tag_ctrl_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic                   sweep_last;

    assign sweep_last = (cnt_q == LAST_SET);

    // Next state, sweep counter and RAM port arbitration
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        upd_gnt   = 1'b0;
        lkup_gnt  = 1'b0;
        ram_req   = 1'b0;
        ram_wr_en = '0;
        ram_addr  = '0;
        ram_wdata = '0;

        unique case (state_q)
            INIT, FLUSH: begin
                ram_req   = 1'b1;
                ram_wr_en = '1;
                ram_addr  = cnt_q;
                cnt_d     = cnt_q + ADDR_WIDTH'(1);
                if (sweep_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush_req) begin
                    state_d = FLUSH;
                end else if (upd_req) begin
                    upd_gnt   = 1'b1;
                    ram_req   = 1'b1;
                    ram_addr  = upd_addr;
                    ram_wr_en = upd_wr_en;
                    ram_wdata = upd_wdata;
                end else if (lkup_req) begin
                    lkup_gnt = 1'b1;
                    ram_req  = 1'b1;
                    ram_addr = lkup_addr;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done   <= 1'b0;
            flush_done  <= 1'b0;
            lkup_rvalid <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done   <= init_done | ((state_q == INIT) && sweep_last);
            flush_done  <= (state_q == FLUSH) && sweep_last;
            lkup_rvalid <= lkup_gnt;
        end
    end

    // RAM read data is already registered; only gate it with the valid
    assign lkup_rdata = lkup_rvalid ? ram_rdata : '0;
    assign busy       = (state_q != RUN);

endmodule
